// File: rtl/pifo_calendar_cpu_access_master.sv
// Host-to-calendar CPU access initiator: one outstanding register request,
// address range check, bounded wait for completion, registered response.
module pifo_calendar_cpu_access_master #(
  parameter int unsigned PIFO_CALENDAR_SIZE        = 1024,
  parameter int unsigned PIFO_CALENDAR_INDEX_WIDTH = 10,
  parameter int unsigned PIFO_ROOT_WIDTH           = 32,
  parameter int unsigned HOST_ADDR_WIDTH           = 16,
  parameter int unsigned TIMEOUT_CYCLES            = 256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 host_req_valid,
  output logic                                 host_req_ready,
  input  logic                                 host_req_wr,
  input  logic [HOST_ADDR_WIDTH-1:0]           host_req_addr,
  input  logic [PIFO_ROOT_WIDTH-1:0]           host_req_wdata,
  output logic                                 host_resp_valid,
  input  logic                                 host_resp_ready,
  output logic                                 host_resp_err,
  output logic [PIFO_ROOT_WIDTH-1:0]           host_resp_data,
  output logic                                 cpu_rd_valid,
  output logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cpu_rd_addr,
  input  logic                                 cpu_rd_result_valid,
  input  logic [PIFO_ROOT_WIDTH-1:0]           cpu_rd_result,
  output logic                                 cpu_wr_valid,
  output logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cpu_wr_addr,
  output logic [PIFO_ROOT_WIDTH-1:0]           cpu_wr_data,
  input  logic                                 cpu_wr_result_valid,
  output logic [15:0]                          stat_timeout_count
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOST_ADDR_WIDTH:0] SIZE_EXT = (HOST_ADDR_WIDTH + 1)'(PIFO_CALENDAR_SIZE);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                               state_q, state_d;
  logic                                 req_wr_q, req_wr_d;
  logic                                 range_err_q, range_err_d;
  logic [TMO_W-1:0]                     tmo_cnt_q, tmo_cnt_d;
  logic                                 req_ready_q, req_ready_d;
  logic                                 resp_valid_q, resp_valid_d;
  logic                                 resp_err_q, resp_err_d;
  logic [PIFO_ROOT_WIDTH-1:0]           resp_data_q, resp_data_d;
  logic                                 rd_valid_q, rd_valid_d;
  logic                                 wr_valid_q, wr_valid_d;
  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cpu_addr_q, cpu_addr_d;
  logic [PIFO_ROOT_WIDTH-1:0]           cpu_wdata_q, cpu_wdata_d;
  logic [15:0]                          stat_q, stat_d;

  logic accept;
  logic addr_oor;
  logic match;
  logic tmo_hit;

  assign accept   = host_req_valid && req_ready_q;
  assign addr_oor = ({1'b0, host_req_addr} >= SIZE_EXT);
  assign match    = (state_q == WAIT) &&
                    (req_wr_q ? cpu_wr_result_valid : cpu_rd_result_valid);
  assign tmo_hit  = (state_q == WAIT) && !match && (tmo_cnt_q == TMO_LAST);

  // State and registered outputs; rst discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_wr_q     <= 1'b0;
      range_err_q  <= 1'b0;
      tmo_cnt_q    <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      rd_valid_q   <= 1'b0;
      wr_valid_q   <= 1'b0;
      cpu_addr_q   <= '0;
      cpu_wdata_q  <= '0;
      stat_q       <= '0;
    end else begin
      state_q      <= state_d;
      req_wr_q     <= req_wr_d;
      range_err_q  <= range_err_d;
      tmo_cnt_q    <= tmo_cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      rd_valid_q   <= rd_valid_d;
      wr_valid_q   <= wr_valid_d;
      cpu_addr_q   <= cpu_addr_d;
      cpu_wdata_q  <= cpu_wdata_d;
      stat_q       <= stat_d;
    end
  end

  // Next-state selection
  // Out-of-range requests still pass through ISSUE (with no strobe) so their
  // error response lands two cycles after accept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: state_d = range_err_q ? RESP : WAIT;
      WAIT:  if (match || tmo_hit) state_d = RESP;
      RESP:  if (host_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the request latch, strobes, response and statistics
  always_comb begin
    req_wr_d     = accept ? host_req_wr : req_wr_q;
    range_err_d  = accept ? addr_oor : range_err_q;
    tmo_cnt_d    = (state_q == WAIT) ? tmo_cnt_q + TMO_W'(1) : '0;
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);

    rd_valid_d   = accept && !addr_oor && !host_req_wr;
    wr_valid_d   = accept && !addr_oor && host_req_wr;
    cpu_addr_d   = cpu_addr_q;
    cpu_wdata_d  = cpu_wdata_q;
    if (accept && !addr_oor) begin
      cpu_addr_d  = host_req_addr[PIFO_CALENDAR_INDEX_WIDTH-1:0];
      cpu_wdata_d = host_req_wdata;
    end

    resp_err_d  = 1'b0;
    resp_data_d = '0;
    unique case (state_q)
      ISSUE: resp_err_d = range_err_q;
      WAIT: begin
        if (match) begin
          resp_data_d = req_wr_q ? '0 : cpu_rd_result;
        end else if (tmo_hit) begin
          resp_err_d = 1'b1;
        end
      end
      RESP: begin
        if (state_d == RESP) begin
          resp_err_d  = resp_err_q;
          resp_data_d = resp_data_q;
        end
      end
      default: ;
    endcase

    stat_d = (tmo_hit && (stat_q != '1)) ? stat_q + 16'd1 : stat_q;
  end

  assign host_req_ready     = req_ready_q;
  assign host_resp_valid    = resp_valid_q;
  assign host_resp_err      = resp_err_q;
  assign host_resp_data     = resp_data_q;
  assign cpu_rd_valid       = rd_valid_q;
  assign cpu_wr_valid       = wr_valid_q;
  assign cpu_rd_addr        = cpu_addr_q;
  assign cpu_wr_addr        = cpu_addr_q;
  assign cpu_wr_data        = cpu_wdata_q;
  assign stat_timeout_count = stat_q;

endmodule
